// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared states, RGB565 layout and default timing for the OV7670 emulator.
`default_nettype none

package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } tx_state_e;

  localparam int RGB_R_BITS  = 5;
  localparam int RGB_G_BITS  = 6;
  localparam int RGB_B_BITS  = 5;
  localparam int RGB565_BITS = RGB_R_BITS + RGB_G_BITS + RGB_B_BITS;

  localparam bit HI_BYTE_FIRST = 1'b1;

  localparam int DEF_WIDTH   = 640;
  localparam int DEF_HEIGHT  = 480;
  localparam int DEF_H_BLANK = 50;
  localparam int DEF_V_BLANK = 5;

endpackage

`default_nettype wire

// File: rtl/ov7670_tx_timing.sv
// ov7670_tx_timing: frame/line counters and state machine; strobes describe the slot
// that the registered outputs will show on the next clock.
`default_nettype none

module ov7670_tx_timing
  import ov7670_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int V_BLANK = DEF_V_BLANK
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic vsync_p,
  output logic href_p,
  output logic first_p,
  output logic fs_p,
  output logic req_n
);

  localparam int L       = 2 * WIDTH + H_BLANK;
  localparam int V_TOTAL = V_BLANK + HEIGHT;
  localparam int HW      = $clog2(L);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(2 * WIDTH - 1);
  localparam logic [VW-1:0] V_BLANK_LAST = VW'(V_BLANK - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  if (WIDTH < 1 || HEIGHT < 1 || H_BLANK < 1 || V_BLANK < 1) begin : g_bad_params
    $error("ov7670_tx_timing: WIDTH, HEIGHT, H_BLANK and V_BLANK must all be >= 1");
  end

  tx_state_e       state, state_n;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_n;
      h_cnt <= h_n;
      v_cnt <= v_n;
    end
  end

  // enable is only looked at in IDLE and on the last clock of the frame
  always_comb begin
    state_n = state;
    h_n     = h_cnt + 1'b1;
    v_n     = v_cnt;
    case (state)
      IDLE: begin
        h_n = '0;
        v_n = '0;
        if (enable) state_n = VBLANK;
      end
      VBLANK: begin
        if (h_cnt == H_LAST) begin
          h_n = '0;
          v_n = v_cnt + 1'b1;
          if (v_cnt == V_BLANK_LAST) state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (h_cnt == H_ACT_LAST) state_n = HBLANK;
      end
      HBLANK: begin
        if (h_cnt == H_LAST) begin
          h_n = '0;
          if (v_cnt == V_LAST) begin
            v_n     = '0;
            state_n = enable ? VBLANK : IDLE;
          end else begin
            v_n     = v_cnt + 1'b1;
            state_n = ACTIVE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign vsync_p = (state == IDLE) || (state == VBLANK);
  assign href_p  = (state == ACTIVE);
  assign first_p = (state == ACTIVE) && !h_cnt[0];
  assign fs_p    = (state == VBLANK) && (h_cnt == '0) && (v_cnt == '0);
  // one slot further ahead so the registered s_ready leads the high-byte slot by a clock
  assign req_n   = (state_n == ACTIVE) && !h_n[0];

endmodule

`default_nettype wire

// File: rtl/ov7670_tx.sv
// ov7670_tx: OV7670-style camera output emulator (RGB565 in, VSYNC/HREF/byte stream out).
// Optional internal byte-counter pattern: define OV7670_TX_TEST_PATTERN_EN.
`default_nettype none

module ov7670_tx
  import ov7670_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int V_BLANK    = DEF_V_BLANK,
  parameter int OBIT_WIDTH = 8,
  parameter int IBIT_WIDTH = RGB565_BITS
) (
  input  logic                  cam_PCLK,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  test_mode,
  input  logic [IBIT_WIDTH-1:0] s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cam_VSYNC,
  output logic                  cam_HREF,
  output logic [OBIT_WIDTH-1:0] cam_dout,
  output logic                  frame_start,
  output logic                  underrun
);

  if (IBIT_WIDTH != 2 * OBIT_WIDTH) begin : g_bad_widths
    $error("ov7670_tx: IBIT_WIDTH must be twice OBIT_WIDTH");
  end

  logic                  vsync_p, href_p, first_p, fs_p, req_n;
  logic                  pattern_on;
  logic [OBIT_WIDTH-1:0] pattern_byte;
  logic [IBIT_WIDTH-1:0] pix_in, pix_hold;
  logic [OBIT_WIDTH-1:0] dout_n;

  ov7670_tx_timing #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .H_BLANK(H_BLANK),
    .V_BLANK(V_BLANK)
  ) u_timing (
    .clk    (cam_PCLK),
    .rst    (rst),
    .enable (enable),
    .vsync_p(vsync_p),
    .href_p (href_p),
    .first_p(first_p),
    .fs_p   (fs_p),
    .req_n  (req_n)
  );

`ifdef OV7670_TX_TEST_PATTERN_EN
  logic [OBIT_WIDTH-1:0] pat_cnt;

  assign pattern_on   = test_mode;
  assign pattern_byte = pat_cnt;

  always_ff @(posedge cam_PCLK or posedge rst) begin
    if (rst)                        pat_cnt <= '0;
    else if (fs_p)                  pat_cnt <= '0;
    else if (pattern_on && href_p)  pat_cnt <= pat_cnt + 1'b1;
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign pattern_on       = 1'b0;
  assign pattern_byte     = '0;
`endif

  // a missing pixel is sent as zero; the line timing never waits for the source
  assign pix_in = s_valid ? s_pixel : '0;

  always_comb begin
    dout_n = '0;
    if (href_p) begin
      if (pattern_on)
        dout_n = pattern_byte;
      else if (first_p)
        dout_n = HI_BYTE_FIRST ? pix_in[IBIT_WIDTH-1 -: OBIT_WIDTH] : pix_in[OBIT_WIDTH-1:0];
      else
        dout_n = HI_BYTE_FIRST ? pix_hold[OBIT_WIDTH-1:0] : pix_hold[IBIT_WIDTH-1 -: OBIT_WIDTH];
    end
  end

  always_ff @(posedge cam_PCLK or posedge rst) begin
    if (rst) begin
      cam_VSYNC   <= 1'b1;
      cam_HREF    <= 1'b0;
      cam_dout    <= '0;
      s_ready     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      pix_hold    <= '0;
    end else begin
      cam_VSYNC   <= vsync_p;
      cam_HREF    <= href_p;
      cam_dout    <= dout_n;
      s_ready     <= req_n && !pattern_on;
      frame_start <= fs_p;
      if (s_ready) pix_hold <= pix_in;
      // a new underrun in the frame_start clock wins over the clear
      underrun    <= (s_ready && !s_valid) || (underrun && !fs_p);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_tx.sv
// tb_ov7670_tx: scoreboard bench for ov7670_tx with a 4x3 frame (L=10, frame=40).
`default_nettype none

module tb_ov7670_tx;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int VB    = 1;
  localparam int L     = 2 * W + HB;
  localparam int FRAME = (VB + H) * L;

  localparam int M_WAIT  = 0;
  localparam int M_FRAME = 1;
  localparam int M_IDLE  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        test_mode = 1'b0;
  logic [15:0] s_pixel = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready, cam_VSYNC, cam_HREF, frame_start, underrun;
  logic [7:0]  cam_dout;

  always #5 clk = ~clk;

  ov7670_tx #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .H_BLANK   (HB),
    .V_BLANK   (VB),
    .OBIT_WIDTH(8),
    .IBIT_WIDTH(16)
  ) dut (
    .cam_PCLK   (clk),
    .rst        (rst),
    .enable     (enable),
    .test_mode  (test_mode),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cam_VSYNC  (cam_VSYNC),
    .cam_HREF   (cam_HREF),
    .cam_dout   (cam_dout),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          mode     = M_WAIT;
  int          pos      = 0;
  int          last_fs  = 0;
  bit          have_fs  = 1'b0;
  bit          en_end   = 1'b1;
  bit          pat_mode = 1'b0;
  bit          drop_frame = 1'b0;
  bit          e_und    = 1'b0;
  bit          und_pend = 1'b0;
  int          href_cnt, rdy_cnt, xfer_cnt, drops, req_idx;
  logic [7:0]  pat_exp  = 8'h00;
  logic [15:0] cur_pix  = 16'h1234;
  logic [7:0]  sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_vsync"}, cam_VSYNC, 1);
    check_eq({pfx, "_href"}, cam_HREF, 0);
    check_eq({pfx, "_dout"}, cam_dout, 0);
    check_eq({pfx, "_ready"}, s_ready, 0);
    check_eq({pfx, "_fs"}, frame_start, 0);
    check_eq({pfx, "_underrun"}, underrun, 0);
  endtask

  task automatic clear_model();
    mode     = M_WAIT;
    have_fs  = 1'b0;
    e_und    = 1'b0;
    und_pend = 1'b0;
    sb.delete();
  endtask

  // One clock: sample outputs on the falling edge, check against the model, then drive the source.
  task automatic step();
    int  line, h, nxt;
    bit  e_vs, e_href, e_fs, e_rdy, drop;
    logic [7:0] exp_b;
    @(negedge clk);
    cyc++;
    if (mode == M_WAIT && frame_start === 1'b1) begin
      mode = M_FRAME;
      pos  = 0;
    end
    if (mode == M_FRAME) begin
      line   = pos / L;
      h      = pos % L;
      nxt    = pos + 1;
      e_vs   = (line < VB);
      e_href = !e_vs && (h < 2 * W);
      e_fs   = (pos == 0);
      e_rdy  = !pat_mode && (nxt < FRAME) && ((nxt / L) >= VB) &&
               ((nxt % L) < 2 * W) && (((nxt % L) % 2) == 0);
      if (e_fs) begin
        if (have_fs) check_eq("fs_period", cyc - last_fs, FRAME);
        last_fs  = cyc;
        have_fs  = 1'b1;
        href_cnt = 0; rdy_cnt = 0; xfer_cnt = 0; drops = 0; req_idx = 0;
        pat_exp  = 8'h00;
      end
      if (pos == FRAME - 1) en_end = enable;
      check_eq("vsync", cam_VSYNC, e_vs);
      check_eq("href", cam_HREF, e_href);
      check_eq("frame_start", frame_start, e_fs);
      check_eq("s_ready", s_ready, e_rdy);
      e_und    = e_fs ? und_pend : (e_und | und_pend);
      und_pend = 1'b0;
      check_eq("underrun", underrun, e_und);
      if (e_href) begin
        if (pat_mode) begin
          check_eq("pattern_byte", cam_dout, pat_exp);
          pat_exp = pat_exp + 8'h01;
        end else if (sb.size() == 0) begin
          check_eq("sb_nonempty", sb.size(), 1);
        end else begin
          exp_b = sb.pop_front();
          check_eq("dout", cam_dout, exp_b);
        end
      end else begin
        check_eq("dout_blank", cam_dout, 0);
      end
      href_cnt += int'(cam_HREF);
      rdy_cnt  += int'(s_ready);
      if (pos == FRAME - 1) begin
        check_eq("href_count", href_cnt, pat_mode ? 2 * W * H : 2 * W * H);
        check_eq("ready_count", rdy_cnt, pat_mode ? 0 : W * H);
        check_eq("xfer_count", xfer_cnt, pat_mode ? 0 : W * H - drops);
      end
      pos++;
      if (pos == FRAME) begin
        pos = 0;
        if (!en_end) begin
          mode    = M_IDLE;
          have_fs = 1'b0;
        end
      end
    end else if (mode == M_IDLE) begin
      check_eq("idle_vsync", cam_VSYNC, 1);
      check_eq("idle_href", cam_HREF, 0);
      check_eq("idle_fs", frame_start, 0);
      check_eq("idle_ready", s_ready, 0);
      check_eq("idle_dout", cam_dout, 0);
      e_und    = e_und | und_pend;
      und_pend = 1'b0;
      check_eq("idle_underrun", underrun, e_und);
    end
    drop    = drop_frame && (req_idx == 5) && (s_ready === 1'b1);
    s_valid = !drop;
    s_pixel = drop ? 16'hDEAD : cur_pix;
    if (s_ready === 1'b1) begin
      req_idx++;
      if (!drop) begin
        sb.push_back(cur_pix[15:8]);
        sb.push_back(cur_pix[7:0]);
        cur_pix  = cur_pix + 16'h4444;
        xfer_cnt++;
      end else begin
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        und_pend = 1'b1;
        drops++;
      end
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs(input string tag);
    for (int k = 0; k < 30 && mode != M_FRAME; k++) step();
    check_eq(tag, (mode == M_FRAME) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    run_steps(3);
    check_reset_outputs("reset");

    rst    = 1'b0;
    enable = 1'b1;
    clear_model();
    wait_fs("first_frame_start");
    run_steps(39 + 40);

    drop_frame = 1'b1;
    run_steps(40);
    drop_frame = 1'b0;

    run_steps(22);
    enable = 1'b0;
    run_steps(18);
    run_steps(30);

    enable = 1'b1;
    clear_model();
    wait_fs("fs_after_reenable");
    run_steps(24);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    clear_model();
    run_steps(3);
    rst = 1'b0;
    wait_fs("fs_after_rst");
    run_steps(40);

`ifdef OV7670_TX_TEST_PATTERN_EN
    #2 rst = 1'b1;
    test_mode = 1'b1;
    pat_mode  = 1'b1;
    clear_model();
    run_steps(2);
    rst = 1'b0;
    wait_fs("fs_pattern");
    run_steps(80);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ov7670_tx.md
Name: ov7670_tx

Overview:
- OV7670-compatible camera output emulator: drives cam_VSYNC, cam_HREF and an 8-bit byte stream from RGB565 pixels.
- Each pixel is sent as two bytes, high byte first, one byte per cam_PCLK.
- It is the transmitting end of the interface that ov7670_if receives.
- Used for loopback tests and FPGA-only bring-up without a physical sensor; pixels come from a valid/ready source (frame buffer reader).

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- H_BLANK, 50, HREF-low clocks after each line's active bytes.
- V_BLANK, 5, blank lines per frame with VSYNC high.
- OBIT_WIDTH, 8, output byte width.
- IBIT_WIDTH, 16, input pixel width (RGB565).

Ports:
- cam_PCLK  input  1  pixel clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  start/continue frame generation; sampled only at frame boundaries.
- test_mode  input  1  select internal pattern (used only with TEST_PATTERN_EN).
- s_pixel  input  IBIT_WIDTH  RGB565 pixel.
- s_valid  input  1  s_pixel valid.
- s_ready  output  1  pixel request; transfer occurs when s_valid && s_ready.
- cam_VSYNC  output  1  high during vertical blank.
- cam_HREF  output  1  high while active bytes are on cam_dout.
- cam_dout  output  OBIT_WIDTH  byte stream.
- frame_start  output  1  one-clock pulse on the first VBLANK clock of each frame.
- underrun  output  1  sticky; set when a pixel was needed and s_valid was low.

Behaviour:
- Reset values: cam_VSYNC=1, cam_HREF=0, cam_dout=0, s_ready=0, frame_start=0, underrun=0; state IDLE; counters 0.
- Reset is asynchronous. Asserting it mid-frame aborts immediately. The next frame starts from VBLANK line 0 after release.
- Line length L = 2*WIDTH+H_BLANK clocks. Frame = (V_BLANK+HEIGHT)*L clocks. Defaults: L=1330, frame=645050.
- Counters:
  - h_cnt: 0..L-1, width $clog2(L).
  - v_cnt: 0..V_BLANK+HEIGHT-1.
  - Both wrap to 0 at their end.
- States:
  - IDLE:
    - cam_VSYNC=1, cam_HREF=0, cam_dout=0.
    - enable=1 → VBLANK with h_cnt=v_cnt=0, frame_start=1 that clock.
  - VBLANK:
    - V_BLANK lines of L clocks, cam_VSYNC=1, cam_HREF=0 throughout.
    - Last clock → ACTIVE.
  - ACTIVE:
    - cam_VSYNC=0.
    - h_cnt 0..2*WIDTH-1: cam_HREF=1. Even h_cnt: high byte s_pixel[15:8]. Odd h_cnt: low byte s_pixel[7:0].
    - → HBLANK.
  - HBLANK:
    - cam_HREF=0, cam_dout=0, for H_BLANK clocks.
    - If lines remain → ACTIVE.
    - After line HEIGHT-1: → VBLANK (new frame, frame_start pulse) if enable=1, else → IDLE.
- enable deasserted mid-frame: the current frame completes fully.
- Outputs are registered. s_ready is high exactly one clock before each even-h_cnt active slot: WIDTH pulses per line, HEIGHT*WIDTH per frame.
- Acceptance and latency: a pixel accepted in clock t appears as the high byte in t+1 and the low byte in t+2. The holding register captures on acceptance.
- Underrun: if s_ready=1 and s_valid=0, the pixel is sent as 0x0000 and underrun is set. Timing never stalls. underrun clears on frame_start; if an underrun and frame_start coincide, set wins.
- s_valid while s_ready=0 is ignored; the source must hold the pixel.
- H_BLANK, V_BLANK ≥1 and WIDTH, HEIGHT ≥1; elaboration fails otherwise.

Optional Feature:
- Macro: OV7670_TX_TEST_PATTERN_EN.
- Defined, test_mode=1:
  - s_ready stays 0 and the source is ignored.
  - cam_dout during HREF carries an 8-bit counter that increments every active byte and resets to 0 at frame_start.
  - underrun is never set.
- Defined, test_mode=0: normal operation.
- Undefined: test_mode is ignored, no pattern logic is built, and behaviour is always normal.

Decomposition:
- Package ov7670_pkg holds:
  - state enum {IDLE, VBLANK, ACTIVE, HBLANK};
  - RGB565 field widths and byte-order constant HI_BYTE_FIRST=1;
  - default timing constants (640/480/50/5).
- Sub-module ov7670_tx_timing holds the h_cnt/v_cnt counters and the state machine, and emits phase strobes. The top handles the pixel register, byte mux, handshake, underrun and pattern logic.

Test Plan (WIDTH=4, HEIGHT=3, H_BLANK=2, V_BLANK=1, L=10, frame=40):
- Reset released, enable=1, source always valid with pixels 0x1234, 0x5678, … → VSYNC high clocks 0-9; line 0 HREF high clocks 10-17 with bytes 12,34,56,78,…; HREF low clocks 18-19; next frame_start at clock 40.
- Count HREF-high clocks per frame → 24. Count s_ready&&s_valid transfers → 12. Period between frame_start pulses → 40.
- Drop s_valid for the 2nd pixel of line 1 → bytes 00,00 in that slot, underrun=1 until the next frame_start, timing unchanged.
- Deassert enable mid-line 1 → frame completes through HBLANK of line 2, then IDLE with VSYNC=1, HREF=0, no further frame_start.
- Assert rst during line 1 active → outputs at reset values immediately (asynchronous); after release with enable=1, a fresh frame_start is emitted and the frame is a full 40 clocks.
- With OV7670_TX_TEST_PATTERN_EN and test_mode=1 → bytes 0x00..0x17 across the frame, s_ready=0, and the counter restarts at 0 in the next frame.
